// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART0 transmit controller.
//               Register offsets, STATUS bit indices, transmitter state
//               encoding and the baud divisor helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   // Register offsets relative to BASE_ADR
   localparam int UART_DATA_OFS = 0;
   localparam int UART_STAT_OFS = 4;

   // STATUS register bit indices
   localparam int ST_READY = 1;
   localparam int ST_BUSY  = 2;

   // Transmitter sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Cycles per bit, rounded to nearest
   function automatic int uart_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_shift.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_shift
// Description : 8N1 frame sequencer. Pulls a byte from the buffer in front
//               of it and shifts it out LSB first with one start and one
//               stop bit, each bit lasting DIV clock cycles. A new frame
//               starts directly out of STOP when another byte is waiting.
// Ports       : clk      - core clock
//               n_reset  - asynchronous active-low reset
//               tx_byte  - byte at the head of the buffer
//               tx_valid - buffer holds at least one byte
//               pop      - consume tx_byte this cycle
//               busy     - sequencer is not idle
//               tx       - serial line, idle high (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_shift
   import uart_pkg::*;
#(
   parameter int DIV = 104
) (
   input  logic       clk,
   input  logic       n_reset,
   input  logic [7:0] tx_byte,
   input  logic       tx_valid,
   output logic       pop,
   output logic       busy,
   output logic       tx
);

   localparam int               CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(DIV - 1);

   tx_state_t        state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic [7:0]       shreg, sh_nxt;
   logic             tx_nxt;
   logic             baud_done;

   assign baud_done = (cnt == '0);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         tx      <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         bit_idx <= bit_nxt;
         shreg   <= sh_nxt;
         tx      <= tx_nxt;
      end
   end

   // tx is registered together with the state, so the line level always
   // matches the state the sequencer is in and never glitches.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      sh_nxt    = shreg;
      tx_nxt    = tx;
      pop       = 1'b0;

      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (tx_valid) begin
               pop       = 1'b1;
               sh_nxt    = tx_byte;
               state_nxt = START;
               cnt_nxt   = CNT_RELOAD;
               tx_nxt    = 1'b0;
            end
         end

         START: begin
            if (baud_done) begin
               state_nxt = DATA;
               cnt_nxt   = CNT_RELOAD;
               bit_nxt   = 3'd0;
               tx_nxt    = shreg[0];
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end

         DATA: begin
            if (baud_done) begin
               cnt_nxt = CNT_RELOAD;
               if (bit_idx == 3'd7) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  // Shift right; the next bit to send is the current bit 1
                  bit_nxt = bit_idx + 3'd1;
                  sh_nxt  = {1'b0, shreg[7:1]};
                  tx_nxt  = shreg[1];
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end

         STOP: begin
            if (baud_done) begin
               cnt_nxt = CNT_RELOAD;
               if (tx_valid) begin
                  // Back-to-back frame: no idle gap after the stop bit
                  pop       = 1'b1;
                  sh_nxt    = tx_byte;
                  state_nxt = START;
                  tx_nxt    = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  tx_nxt    = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/uart0_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart0_tx_ctrl
// Description : Memory-mapped UART0 transmit controller. Decodes DATA
//               (BASE_ADR+0) and STATUS (BASE_ADR+4), buffers bytes written
//               to DATA and hands them to uart_tx_shift for 8N1 output.
//               Build option UART0_TX_FIFO_EN: when defined the buffer is a
//               FIFO_DEPTH-entry FIFO (power of 2, at least 2); otherwise it
//               is a single holding register.
// Ports       : clk       - core clock
//               n_reset   - asynchronous active-low reset
//               bus_valid - access strobe, one cycle per access
//               bus_wren  - byte write enables, 0 = read
//               bus_adr   - byte address
//               bus_wdata - write data, byte 0 is the character
//               bus_rdata - read data, valid the cycle after bus_valid
//               bus_ready - acknowledge, one cycle after a hitting access
//               tx        - serial line, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart0_tx_ctrl
   import uart_pkg::*;
#(
   parameter int          CLK_HZ     = 12000000,
   parameter int          BAUD       = 115200,
   parameter logic [31:0] BASE_ADR   = 32'h0001_0010,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        bus_valid,
   input  logic [3:0]  bus_wren,
   input  logic [31:0] bus_adr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ready,
   output logic        tx
);

   localparam int DIV = uart_div(CLK_HZ, BAUD);

   logic        hit, is_read, sel_data, sel_stat;
   logic [2:0]  ofs;
   logic        data_wr, push, pop;
   logic        full, empty, ready, busy, shift_busy;
   logic [7:0]  head;
   logic [7:0]  last_byte;
   logic [31:0] status, read_val;

   // ------------------------------------------------------------------
   // Bus decode: the block occupies one 8-byte window
   // ------------------------------------------------------------------
   assign hit      = bus_valid && (bus_adr[31:3] == BASE_ADR[31:3]);
   assign is_read  = (bus_wren == 4'b0000);
   assign ofs      = {bus_adr[2], 2'b00};
   assign sel_data = (ofs == 3'(UART_DATA_OFS));
   assign sel_stat = (ofs == 3'(UART_STAT_OFS));
   assign data_wr  = hit && sel_data && bus_wren[0];

   // ready reflects the occupancy before this cycle, so a write that
   // coincides with a pop from a full buffer is still dropped.
   assign ready    = !full;
   assign push     = data_wr && ready;
   assign busy     = shift_busy || !empty;

   always_comb begin
      status           = '0;
      status[ST_READY] = ready;
      status[ST_BUSY]  = busy;
   end

   always_comb begin
      read_val = '0;
      if (sel_stat)
         read_val = status;
      else if (sel_data)
         read_val = {24'd0, last_byte};
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bus_ready <= 1'b0;
         bus_rdata <= '0;
         last_byte <= 8'd0;
      end else begin
         bus_ready <= hit;
         bus_rdata <= (hit && is_read) ? read_val : '0;
         if (push)
            last_byte <= bus_wdata[7:0];
      end
   end

   // ------------------------------------------------------------------
   // Transmit buffer
   // ------------------------------------------------------------------
`ifdef UART0_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   // One extra pointer bit tells full from empty when the indices match
   logic [AW:0]   wr_ptr, rd_ptr;
   logic [7:0]    mem [FIFO_DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[AW-1:0]] <= bus_wdata[7:0];
   end
`else
   logic       hold_full;
   logic [7:0] hold_byte;

   assign empty = !hold_full;
   assign full  = hold_full;
   assign head  = hold_byte;

   // push needs an empty register and pop a full one, so they never collide
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         hold_full <= 1'b0;
         hold_byte <= 8'd0;
      end else if (push) begin
         hold_full <= 1'b1;
         hold_byte <= bus_wdata[7:0];
      end else if (pop) begin
         hold_full <= 1'b0;
      end
   end
`endif

   // ------------------------------------------------------------------
   // Frame sequencer
   // ------------------------------------------------------------------
   uart_tx_shift #(
      .DIV      (DIV)
   ) u_shift (
      .clk      (clk),
      .n_reset  (n_reset),
      .tx_byte  (head),
      .tx_valid (!empty),
      .pop      (pop),
      .busy     (shift_busy),
      .tx       (tx)
   );

   // Bits of the bus that this register block never looks at
   logic unused;
   assign unused = &{1'b0, bus_wdata[31:8], bus_adr[1:0], (FIFO_DEPTH != 0)};

endmodule
`default_nettype wire

// File: tb/tb_uart0_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart0_tx_ctrl
// Description : Self-checking bench for uart0_tx_ctrl at default parameters.
//               Reference model works on frame timing: each accepted byte
//               owns a 10*DIV window starting at max(accept+2, end of the
//               previous frame); buffer occupancy, STATUS and the expected
//               line level are derived from those windows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart0_tx_ctrl;

   localparam logic [31:0] BASE  = 32'h0001_0010;
   localparam logic [31:0] STAT  = 32'h0001_0014;
   localparam int          DIV   = 104;        // round(12 MHz / 115200)
   localparam int          FRAME = 10 * DIV;
`ifdef UART0_TX_FIFO_EN
   localparam int          CAP   = 4;
`else
   localparam int          CAP   = 1;
`endif

   logic        clk       = 1'b0;
   logic        n_reset   = 1'b0;
   logic        bus_valid = 1'b0;
   logic [3:0]  bus_wren  = 4'd0;
   logic [31:0] bus_adr   = 32'd0;
   logic [31:0] bus_wdata = 32'd0;
   logic [31:0] bus_rdata;
   logic        bus_ready;
   logic        tx;

   uart0_tx_ctrl dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .bus_valid (bus_valid),
      .bus_wren  (bus_wren),
      .bus_adr   (bus_adr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model ----------------
   typedef struct {
      int         a;   // cycle the write was presented
      int         s;   // first cycle of the start bit
      logic [7:0] b;
   } frame_t;

   frame_t     frames[$];
   logic [7:0] m_last = 8'd0;

   function automatic int m_occ(input int n);
      int c = 0;
      foreach (frames[i])
         if (frames[i].a + 1 <= n && n <= frames[i].s - 1) c++;
      return c;
   endfunction

   function automatic bit m_busy(input int n);
      foreach (frames[i])
         if (frames[i].a + 1 <= n && n < frames[i].s + FRAME) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] m_status(input int n);
      logic [31:0] r = 32'd0;
      r[1] = (m_occ(n) < CAP);
      r[2] = m_busy(n);
      return r;
   endfunction

   function automatic int m_end();
      return (frames.size() > 0) ? frames[$].s + FRAME : 0;
   endfunction

   function automatic logic m_tx(input int t);
      int k;
      foreach (frames[i]) begin
         if (t >= frames[i].s && t < frames[i].s + FRAME) begin
            k = (t - frames[i].s) / DIV;
            if (k == 0) return 1'b0;
            if (k <= 8) return frames[i].b[k-1];
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   // ---------------- line monitor ----------------
   bit   mon_en = 1'b0;
   int   line_err = 0, first_cyc = 0;
   logic first_act, first_exp;

   always @(negedge clk) begin
      if (mon_en && n_reset) begin
         if (tx !== m_tx(cyc)) begin
            if (line_err == 0) begin
               first_cyc = cyc;
               first_act = tx;
               first_exp = m_tx(cyc);
            end
            line_err++;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_line(input string name);
      checks++;
      if (line_err != 0) begin
         failures++;
         $display("FAIL %s: %0d wrong tx cycles, first at cycle %0d got %0b expected %0b",
                  name, line_err, first_cyc, first_act, first_exp);
      end
      line_err = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) tick();
   endtask

   // One bus access; updates the model and returns what the DUT answered
   task automatic access(input logic [31:0] adr, input logic [3:0] wren, input logic [31:0] wd,
                         output logic rdy, output logic [31:0] rd, output bit exp_hit,
                         output logic [31:0] exp_rd);
      int a = cyc;
      exp_hit = (adr[31:3] == BASE[31:3]);
      exp_rd  = adr[2] ? m_status(a) : {24'd0, m_last};
      if (exp_hit && !adr[2] && wren[0] && m_occ(a) < CAP) begin
         frames.push_back('{a: a, s: ((a + 2) > m_end()) ? a + 2 : m_end(), b: wd[7:0]});
         m_last = wd[7:0];
      end
      bus_valid = 1'b1;
      bus_adr   = adr;
      bus_wren  = wren;
      bus_wdata = wd;
      tick();
      bus_valid = 1'b0;
      bus_wren  = 4'd0;
      rdy = bus_ready;
      rd  = bus_rdata;
   endtask

   // Access checked against the model
   task automatic acc(input string name, input logic [31:0] adr, input logic [3:0] wren,
                      input logic [31:0] wd, output logic [31:0] rd);
      logic rdy; bit h; logic [31:0] er;
      access(adr, wren, wd, rdy, rd, h, er);
      check({name, "_ready"}, {31'd0, rdy}, {31'd0, h});
      if (h && wren == 4'd0) check({name, "_rdata"}, rd, er);
   endtask

   // ---------------- decode vectors ----------------
   typedef struct {
      logic [31:0] adr;
      logic [3:0]  wren;
      logic [31:0] wdata;
      bit          exp_ready;
      bit          chk_rd;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[10];

   initial begin
      logic [31:0] rd;
      logic        rdy;
      bit          h;
      logic [31:0] er;
      int          a0;
      logic [9:0]  seq;

      // ---- reset ----
      tick(); tick();
      check("rst_tx",    {31'd0, tx},        32'd1);
      check("rst_ready", {31'd0, bus_ready}, 32'd0);
      check("rst_rdata", bus_rdata,          32'd0);
      n_reset = 1'b1;
      mon_en  = 1'b1;
      tick();

      // ---- decode table ----
      vecs[0] = '{STAT,          4'h0, 32'h0,  1, 1, 32'h2};
      vecs[1] = '{BASE,          4'h0, 32'h0,  1, 1, 32'h0};
      vecs[2] = '{STAT,          4'hF, 32'h55, 1, 0, 32'h0};
      vecs[3] = '{32'h0001_0018, 4'h0, 32'h0,  0, 0, 32'h0};
      vecs[4] = '{32'h0001_0018, 4'h1, 32'h55, 0, 0, 32'h0};
      vecs[5] = '{32'h0001_0008, 4'h1, 32'h77, 0, 0, 32'h0};
      vecs[6] = '{STAT,          4'h0, 32'h0,  1, 1, 32'h2};
      vecs[7] = '{BASE,          4'h0, 32'h0,  1, 1, 32'h0};
      vecs[8] = '{32'h1001_0010, 4'h1, 32'h66, 0, 0, 32'h0};
      vecs[9] = '{STAT,          4'h0, 32'h0,  1, 1, 32'h2};
      for (int i = 0; i < 10; i++) begin
         access(vecs[i].adr, vecs[i].wren, vecs[i].wdata, rdy, rd, h, er);
         check($sformatf("vec%0d_ready", i), {31'd0, rdy}, {31'd0, vecs[i].exp_ready});
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         tick();
      end
      repeat (20) tick();
      check_line("decode_line");

      // ---- single byte 0x61 ----
      a0 = cyc;
      acc("wr61", BASE, 4'h1, 32'h61, rd);
      check("wr61_pre_fall", {31'd0, tx}, 32'd1);
      tick();
      check("wr61_fall", {31'd0, tx}, 32'd0);
      acc("wr61_stat_mid", STAT, 4'h0, 32'h0, rd);
      check("wr61_stat_mid_val", rd, 32'h6);
      seq = 10'b1011000010;   // bit k of seq is line bit k
      for (int k = 0; k < 10; k++) begin
         wait_until(a0 + 2 + k * DIV + DIV / 2);
         check($sformatf("wr61_bit%0d", k), {31'd0, tx}, {31'd0, seq[k]});
      end
      wait_until(a0 + 2 + FRAME);
      acc("wr61_stat_end", STAT, 4'h0, 32'h0, rd);
      check("wr61_stat_end_val", rd, 32'h2);
      acc("wr61_data", BASE, 4'h0, 32'h0, rd);
      check("wr61_data_val", rd, 32'h61);
      check_line("wr61_line");

`ifndef UART0_TX_FIFO_EN
      // ---- holding register full ----
      a0 = cyc;
      acc("hold41", BASE, 4'h1, 32'h41, rd);
      tick();
      acc("hold42", BASE, 4'h1, 32'h42, rd);
      tick();
      acc("hold43", BASE, 4'h1, 32'h43, rd);
      acc("hold_data", BASE, 4'h0, 32'h0, rd);
      check("hold_data_val", rd, 32'h42);
      acc("hold_stat", STAT, 4'h0, 32'h0, rd);
      check("hold_stat_val", rd, 32'h4);
      wait_until(a0 + 2 + FRAME - 1);
      check("hold_stop1", {31'd0, tx}, 32'd1);
      tick();
      check("hold_start2", {31'd0, tx}, 32'd0);
      wait_until(a0 + 2 + 2 * FRAME);
      acc("hold_stat_end", STAT, 4'h0, 32'h0, rd);
      check("hold_stat_end_val", rd, 32'h2);
      repeat (FRAME + 20) tick();
      check_line("hold_line");
`else
      // ---- FIFO fill ----
      a0 = cyc;
      for (int i = 0; i < 5; i++)
         acc($sformatf("fifo_wr%0d", i), BASE, 4'h1, 32'h30 + i, rd);
      acc("fifo_stat", STAT, 4'h0, 32'h0, rd);
      check("fifo_stat_val", rd, 32'h4);
      wait_until(a0 + 2 + 4 * FRAME);
      check("fifo_start5", {31'd0, tx}, 32'd0);
      wait_until(a0 + 2 + 5 * FRAME);
      acc("fifo_stat_end", STAT, 4'h0, 32'h0, rd);
      check("fifo_stat_end_val", rd, 32'h2);
      check_line("fifo_line");
`endif

      // ---- reset mid-frame ----
      a0 = cyc;
      acc("rstmid_wr", BASE, 4'h1, 32'h61, rd);
      wait_until(a0 + 2 + 4 * DIV + 30);
      check("rstmid_bit3", {31'd0, tx}, 32'd0);
      #3;
      n_reset = 1'b0;
      #1;
      check("rstmid_tx_async", {31'd0, tx}, 32'd1);
      frames.delete();
      m_last = 8'd0;
      tick(); tick();
      check("rstmid_ready", {31'd0, bus_ready}, 32'd0);
      n_reset = 1'b1;
      tick();
      acc("rstmid_stat", STAT, 4'h0, 32'h0, rd);
      check("rstmid_stat_val", rd, 32'h2);
      repeat (FRAME + 100) tick();
      check_line("rstmid_line");

      // ---- randomized traffic ----
      for (int i = 0; i < 60; i++) begin
         int gap, op;
         logic [3:0] we;
         gap = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 600) : $urandom_range(0, 4);
         repeat (gap) tick();
         op = $urandom_range(0, 9);
         case ($urandom_range(0, 2))
            0:       we = 4'b0001;
            1:       we = 4'b1111;
            default: we = 4'b0011;
         endcase
         case (op)
            0, 1, 2, 3: acc("rnd_wr", BASE, we, $urandom, rd);
            4:          acc("rnd_wr_nob0", BASE, 4'b0010, $urandom, rd);
            5, 6:       acc("rnd_stat", STAT, 4'h0, 32'h0, rd);
            7:          acc("rnd_data", BASE, 4'h0, 32'h0, rd);
            8:          acc("rnd_miss", BASE + 32'd8 + 32'($urandom_range(0, 7) * 4),
                            ($urandom_range(0, 1) == 1) ? 4'h1 : 4'h0, $urandom, rd);
            default:    acc("rnd_stat_wr", STAT, 4'hF, $urandom, rd);
         endcase
      end
      wait_until(m_end() + 4);
      acc("rnd_stat_end", STAT, 4'h0, 32'h0, rd);
      check("rnd_stat_end_val", rd, 32'h2);
      check_line("rnd_line");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded 80000 cycles at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
